// File: rtl/spike_sched_pkg.sv
// spike_sched_pkg: shared FSM type, default sizes, node layout and wrap-aware timestamp compare
package spike_sched_pkg;
  localparam int N_FIFO_DEF = 16;
  localparam int TS_W_DEF = 14;
  typedef enum logic [2:0] {IDLE, SNAP, CMP, GRANT, WAIT} state_t;
  typedef struct packed {
    logic valid;
    logic [$clog2(N_FIFO_DEF)-1:0] idx;
    logic [TS_W_DEF-1:0] ts;
  } node_t;
  // x is older than y when (x - y) mod 2^w has its top bit set; operands arrive zero-extended
  function automatic logic older(input logic [31:0] x, input logic [31:0] y, input int unsigned w);
    logic [31:0] d;
    d = x - y;
    return d[5'(w - 1)];
  endfunction
endpackage

// File: rtl/ts_min_node.sv
// ts_min_node: one registered level of the oldest-timestamp tree; SCHED_RR_TIE_EN selects rotating tie-break
module ts_min_node
  import spike_sched_pkg::*;
#(
  parameter int TS_W = TS_W_DEF,
  parameter int IDX_W = $clog2(N_FIFO_DEF),
  parameter int NW = 1 + IDX_W + TS_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NW-1:0] a_i,
  input  logic [NW-1:0] b_i,
`ifdef SCHED_RR_TIE_EN
  input  logic [IDX_W-1:0] last_idx_i,
`endif
  output logic [NW-1:0] y_o
);
  typedef struct packed {
    logic valid;
    logic [IDX_W-1:0] idx;
    logic [TS_W-1:0] ts;
  } nd_t;
  nd_t a, b, y_d, y_q;
  logic b_older, b_wins;
  assign a = a_i;
  assign b = b_i;
  assign b_older = older(32'(b.ts), 32'(a.ts), TS_W);
`ifdef SCHED_RR_TIE_EN
  logic [IDX_W-1:0] dist_a, dist_b;
  assign dist_a = a.idx - last_idx_i - IDX_W'(1);
  assign dist_b = b.idx - last_idx_i - IDX_W'(1);
  assign b_wins = b.valid && (!a.valid || b_older || (b.ts == a.ts && dist_b < dist_a));
`else
  assign b_wins = b.valid && (!a.valid || b_older);
`endif
  assign y_d = b_wins ? b : a;
  assign y_o = y_q;
  // register the winner of this pair, one tree level per clock
  always_ff @(posedge clk) y_q <= rst ? '0 : y_d;
endmodule

// File: rtl/spike_fifo_scheduler.sv
// spike_fifo_scheduler: time-ordered one-hot read scheduler for the spike FIFO bank (option: SCHED_RR_TIE_EN)
module spike_fifo_scheduler
  import spike_sched_pkg::*;
#(
  parameter int N_FIFO = N_FIFO_DEF,
  parameter int TS_W = TS_W_DEF,
  parameter int IDX_W = $clog2(N_FIFO)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_FIFO-1:0]      empty_group,
  input  logic [N_FIFO*TS_W-1:0] head_ts,
  input  logic [3:0]             CTRL_STATE,
  input  logic [3:0]             CTRL_NEXT_STATE,
  input  logic                   AER_IN_BUSY,
  input  logic                   core_done,
  output logic [N_FIFO-1:0]      grant_out,
  output logic [IDX_W-1:0]       grant_idx,
  output logic [TS_W-1:0]        grant_ts,
  output logic                   signal_from_arbit
);
  localparam int NW = 1 + IDX_W + TS_W;
  typedef struct packed {
    logic valid;
    logic [IDX_W-1:0] idx;
    logic [TS_W-1:0] ts;
  } nd_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [N_FIFO-1:0] valid_q;
  logic [TS_W-1:0] ts_q [N_FIFO];
  logic [NW-1:0] tree [1:2*N_FIFO-1];
  nd_t root;
  logic core_ok, do_grant;
  logic [N_FIFO-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TS_W-1:0] gts_q, gts_d;
  logic sfa_q;
  assign core_ok = (CTRL_STATE == CTRL_NEXT_STATE) && !AER_IN_BUSY;
  assign root = tree[1];
  assign do_grant = (state_q == GRANT) && core_ok && root.valid;
  assign grant_out = grant_q;
  assign grant_idx = idx_q;
  assign grant_ts = gts_q;
  assign signal_from_arbit = sfa_q;
`ifdef SCHED_RR_TIE_EN
  logic [IDX_W-1:0] last_q;
  // rotating-priority pointer; after reset lane 0 is first in line
  always_ff @(posedge CLK) last_q <= RST ? '1 : (do_grant ? root.idx : last_q);
`endif
  // capture head timestamps and non-empty lanes during SNAP, hold them through CMP/GRANT
  always_ff @(posedge CLK)
    if (RST) begin
      valid_q <= '0;
      for (int i = 0; i < N_FIFO; i++) ts_q[i] <= '0;
    end else if (state_q == SNAP) begin
      valid_q <= ~empty_group;
      for (int i = 0; i < N_FIFO; i++) ts_q[i] <= head_ts[TS_W*i +: TS_W];
    end
  for (genvar i = 0; i < N_FIFO; i++) begin : g_leaf
    assign tree[N_FIFO+i] = {valid_q[i], IDX_W'(i), ts_q[i]};
  end
  for (genvar k = 1; k < N_FIFO; k++) begin : g_node
    ts_min_node #(.TS_W(TS_W), .IDX_W(IDX_W)) u_node (
      .clk(CLK),
      .rst(RST),
      .a_i(tree[2*k]),
      .b_i(tree[2*k+1]),
`ifdef SCHED_RR_TIE_EN
      .last_idx_i(last_q),
`endif
      .y_o(tree[k])
    );
  end
  // FSM state register and compare-level counter
  always_ff @(posedge CLK)
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  // FSM next state: CMP lasts one cycle per tree level
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    case (state_q)
      IDLE: state_d = (~&empty_group && core_ok) ? SNAP : IDLE;
      SNAP: state_d = CMP;
      CMP: begin
        state_d = (cnt_q == 3'(IDX_W - 1)) ? GRANT : CMP;
        cnt_d = cnt_q + 3'd1;
      end
      GRANT: state_d = do_grant ? WAIT : IDLE;
      WAIT: state_d = core_done ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
  end
  // FSM outputs: one-hot pulse and grant bookkeeping only when a grant is issued
  always_comb begin
    grant_d = do_grant ? N_FIFO'(1) << root.idx : '0;
    idx_d = do_grant ? root.idx : idx_q;
    gts_d = do_grant ? root.ts : gts_q;
  end
  // output registers; signal_from_arbit trails the read pulse by one cycle
  always_ff @(posedge CLK)
    if (RST) begin
      grant_q <= '0;
      idx_q <= '0;
      gts_q <= '0;
      sfa_q <= 1'b0;
    end else begin
      grant_q <= grant_d;
      idx_q <= idx_d;
      gts_q <= gts_d;
      sfa_q <= |grant_q;
    end
endmodule

// File: tb/tb_spike_fifo_scheduler.sv
// tb_spike_fifo_scheduler: directed self-checking bench for the spike FIFO scheduler
module tb_spike_fifo_scheduler;
  localparam int N = 16;
  localparam int W = 14;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] empty_group;
  logic [N*W-1:0] head_ts;
  logic [3:0] cs, ns;
  logic busy, core_done;
  logic [N-1:0] grant_out;
  logic [3:0] grant_idx;
  logic [W-1:0] grant_ts;
  logic sfa;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spike_fifo_scheduler dut (
    .CLK(clk),
    .RST(rst),
    .empty_group(empty_group),
    .head_ts(head_ts),
    .CTRL_STATE(cs),
    .CTRL_NEXT_STATE(ns),
    .AER_IN_BUSY(busy),
    .core_done(core_done),
    .grant_out(grant_out),
    .grant_idx(grant_idx),
    .grant_ts(grant_ts),
    .signal_from_arbit(sfa)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ts(input int i, input int v);
    head_ts[W*i +: W] = W'(v);
  endtask

  task automatic wait_grant(output int k);
    k = 0;
    while (k < 20) begin
      tick();
      k++;
      if (grant_out != '0) return;
    end
    k = 99;
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    empty_group = '1;
    head_ts = '0;
    cs = 4'd0;
    ns = 4'd0;
    busy = 1'b0;
    core_done = 1'b0;
    tick(3);
    checks++;
    if ({grant_out, grant_idx, grant_ts, sfa} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got out=%h idx=%0d ts=%0d sfa=%b, expected all 0", grant_out, grant_idx, grant_ts, sfa);
    end
    rst = 1'b0;
    tick(2);
    checks++;
    if ({grant_out, grant_idx, grant_ts, sfa} !== '0) begin
      errors++;
      $display("FAIL reset_release: got out=%h idx=%0d ts=%0d sfa=%b, expected all 0", grant_out, grant_idx, grant_ts, sfa);
    end
  endtask

  task automatic test_single();
    int k;
    empty_group = 16'hFFF7;
    set_ts(3, 100);
    wait_grant(k);
    checks++;
    if (k !== 7) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles, expected 7", k);
    end
    checks++;
    if (grant_out !== 16'h0008 || grant_idx !== 4'd3 || grant_ts !== 14'd100) begin
      errors++;
      $display("FAIL single_grant: got out=%h idx=%0d ts=%0d, expected 0008/3/100", grant_out, grant_idx, grant_ts);
    end
    tick();
    checks++;
    if (grant_out !== '0 || sfa !== 1'b1) begin
      errors++;
      $display("FAIL single_sfa: got out=%h sfa=%b, expected 0000/1", grant_out, sfa);
    end
    tick();
    checks++;
    if (sfa !== 1'b0) begin
      errors++;
      $display("FAIL single_sfa_drop: got %b, expected 0", sfa);
    end
    empty_group = '1;
    pulse_done();
  endtask

  task automatic test_min();
    int k;
    empty_group = 16'hFDDE;
    set_ts(0, 500);
    set_ts(5, 20);
    set_ts(9, 300);
    set_ts(12, 1);
    wait_grant(k);
    checks++;
    if (k !== 7 || grant_out !== 16'h0020 || grant_idx !== 4'd5 || grant_ts !== 14'd20) begin
      errors++;
      $display("FAIL min_select: got k=%0d out=%h idx=%0d ts=%0d, expected 7/0020/5/20", k, grant_out, grant_idx, grant_ts);
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if (grant_out !== '0) begin
        errors++;
        $display("FAIL min_no_second: got %h at cycle %0d, expected 0000", grant_out, n);
      end
    end
    empty_group = '1;
    pulse_done();
  endtask

`ifndef SCHED_RR_TIE_EN
  task automatic test_tie();
    int k;
    empty_group = 16'hFF7B;
    set_ts(2, 42);
    set_ts(7, 42);
    wait_grant(k);
    checks++;
    if (k !== 7 || grant_out !== 16'h0004 || grant_idx !== 4'd2) begin
      errors++;
      $display("FAIL tie_low_idx: got k=%0d out=%h idx=%0d, expected 7/0004/2", k, grant_out, grant_idx);
    end
    empty_group = '1;
    pulse_done();
  endtask
`endif

  task automatic test_wrap();
    int k;
    empty_group = 16'hFFED;
    set_ts(1, 16380);
    set_ts(4, 3);
    wait_grant(k);
    checks++;
    if (k !== 7 || grant_out !== 16'h0002 || grant_idx !== 4'd1 || grant_ts !== 14'd16380) begin
      errors++;
      $display("FAIL wrap_cmp: got k=%0d out=%h idx=%0d ts=%0d, expected 7/0002/1/16380", k, grant_out, grant_idx, grant_ts);
    end
    empty_group = '1;
    pulse_done();
  endtask

  task automatic test_busy();
    int k;
    empty_group = 16'hFFBF;
    set_ts(6, 9);
    for (int n = 0; n < 6; n++) begin
      tick();
      checks++;
      if (grant_out !== '0) begin
        errors++;
        $display("FAIL busy_early: got %h at cycle %0d, expected 0000", grant_out, n);
      end
    end
    busy = 1'b1;
    tick(2);
    busy = 1'b0;
    cs = 4'd1;
    ns = 4'd2;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (grant_out !== '0) begin
        errors++;
        $display("FAIL busy_held: got %h at cycle %0d, expected 0000", grant_out, n);
      end
    end
    cs = 4'd3;
    ns = 4'd3;
    wait_grant(k);
    checks++;
    if (k !== 7 || grant_out !== 16'h0040 || grant_idx !== 4'd6) begin
      errors++;
      $display("FAIL busy_release: got k=%0d out=%h idx=%0d, expected 7/0040/6", k, grant_out, grant_idx);
    end
    empty_group = '1;
    pulse_done();
  endtask

  task automatic test_late_empty();
    int k;
    empty_group = 16'hFBFF;
    set_ts(10, 77);
    tick(2);
    empty_group = '1;
    wait_grant(k);
    checks++;
    if (k !== 5 || grant_out !== 16'h0400 || grant_ts !== 14'd77) begin
      errors++;
      $display("FAIL late_empty: got k=%0d out=%h ts=%0d, expected 5/0400/77", k, grant_out, grant_ts);
    end
    pulse_done();
  endtask

  task automatic test_reset_wait();
    int k;
    empty_group = 16'hFFFE;
    set_ts(0, 5);
    wait_grant(k);
    checks++;
    if (grant_out !== 16'h0001 || grant_ts !== 14'd5) begin
      errors++;
      $display("FAIL rw_grant: got out=%h ts=%0d, expected 0001/5", grant_out, grant_ts);
    end
    tick();
    empty_group = '1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({grant_out, grant_idx, grant_ts, sfa} !== '0) begin
      errors++;
      $display("FAIL rw_outputs: got out=%h idx=%0d ts=%0d sfa=%b, expected all 0", grant_out, grant_idx, grant_ts, sfa);
    end
    pulse_done();
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (grant_out !== '0 || sfa !== 1'b0) begin
        errors++;
        $display("FAIL rw_done_ignored: got out=%h sfa=%b, expected 0000/0", grant_out, sfa);
      end
    end
    empty_group = 16'hF7FF;
    set_ts(11, 8);
    wait_grant(k);
    checks++;
    if (k !== 7 || grant_out !== 16'h0800 || grant_idx !== 4'd11) begin
      errors++;
      $display("FAIL rw_idle_restart: got k=%0d out=%h idx=%0d, expected 7/0800/11", k, grant_out, grant_idx);
    end
    empty_group = '1;
    pulse_done();
  endtask

`ifdef SCHED_RR_TIE_EN
  task automatic test_rr();
    int k;
    rst = 1'b1;
    empty_group = '1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_ts(i, 7);
    empty_group = '0;
    for (int g = 0; g <= N; g++) begin
      wait_grant(k);
      checks++;
      if (k !== 7 || grant_idx !== 4'(g % N)) begin
        errors++;
        $display("FAIL rr_rotate: grant %0d got k=%0d idx=%0d, expected 7/%0d", g, k, grant_idx, g % N);
      end
      pulse_done();
    end
    empty_group = '1;
    tick(2);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_min();
`ifndef SCHED_RR_TIE_EN
    test_tie();
`endif
    test_wrap();
    test_busy();
    test_late_empty();
    test_reset_wait();
`ifdef SCHED_RR_TIE_EN
    test_rr();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
